// File: rtl/ahb_xfer_scheduler_pkg.sv
// Shared types and defaults for the AHB transfer scheduler.
package ahb_sched_pkg;

    // Scheduler FSM states, kept as plain constants for older tool flows
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARB     = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] ERR     = 3'd4;

    // Which client received the most recent bus grant
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_t;

    localparam int DEF_ADDR_STEP = 4;
    localparam int DEF_TIMEOUT   = 255;

    // Read wins when only it is ready, or when both are ready and write went last
    function automatic logic grant_read(input logic rd_ok, input logic wr_ok, input grant_t last);
        return rd_ok && (!wr_ok || last == WRITE);
    endfunction

endpackage

// File: rtl/ahb_xfer_scheduler_if.sv
// Strobe/address/data bundle between the scheduler and the AHB master engine.
interface ahb_xfer_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] next_raddr;
    logic [ADDR_W-1:0] next_waddr;
    logic [DATA_W-1:0] buffer2_data;
    logic [DATA_W-1:0] sram_data;
    logic              read_complete;
    logic              write_complete;

    modport master (
        output re, we, next_raddr, next_waddr, buffer2_data,
        input  sram_data, read_complete, write_complete
    );

    modport slave (
        input  re, we, next_raddr, next_waddr, buffer2_data,
        output sram_data, read_complete, write_complete
    );
endinterface

// File: rtl/xfer_addr_counter.sv
// Per-direction word counter: latches base and word limit at frame start and
// produces the current word address plus a "all words done" flag.
module xfer_addr_counter
    import ahb_sched_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  limit,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  limit_q;
    logic [CNT_W-1:0]  cnt;

    // Frame start reloads base/limit and restarts the count; completions advance it
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            limit_q <= '0;
            cnt     <= '0;
        end else if (load) begin
            base_q  <= base;
            limit_q <= limit;
            cnt     <= '0;
        end else if (inc && (cnt < limit_q)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Address wraps silently modulo 2^ADDR_W
    assign addr = base_q + (ADDR_W'(cnt) * ADDR_W'(ADDR_STEP));
    assign done = (cnt >= limit_q);

endmodule

// File: rtl/ahb_xfer_scheduler.sv
// Arbitrates one AHB master between a pixel-fetch reader and a writeback
// writer, walking both address streams per frame and flagging bus timeouts.
module ahb_xfer_scheduler
    import ahb_sched_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = DEF_ADDR_STEP,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              busy,
    output logic              frame_done,
    output logic              error,
    ahb_xfer_scheduler_if.master bus
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [2:0]        state;
    grant_t            last_grant;
    logic [WAIT_W-1:0] wait_cnt;

    logic              re_q;
    logic              we_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_done;
    logic              wr_done;
    logic              frame_load;
    logic              rd_inc;
    logic              wr_inc;
    logic              rd_ok;
    logic              wr_ok;
    logic              pick_rd;
    logic              pick_wr;

    // A new frame may only begin from IDLE or after a timeout
    assign frame_load = start && ((state == IDLE) || (state == ERR));
    assign rd_inc     = (state == RD_WAIT) && bus.read_complete;
    assign wr_inc     = (state == WR_WAIT) && bus.write_complete;

    assign rd_ok   = rd_req && !rd_done;
    assign wr_ok   = wr_req && !wr_done;
    assign pick_rd = grant_read(rd_ok, wr_ok, last_grant);
    assign pick_wr = wr_ok && !pick_rd;

    xfer_addr_counter #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_rd_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (frame_load),
        .base  (rd_base),
        .limit (num_words),
        .inc   (rd_inc),
        .addr  (rd_addr),
        .done  (rd_done)
    );

    xfer_addr_counter #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_wr_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (frame_load),
        .base  (wr_base),
        .limit (num_words),
        .inc   (wr_inc),
        .addr  (wr_addr),
        .done  (wr_done)
    );

    // Main scheduler: frame control, fair grants, completion handling and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= WRITE;
            wait_cnt   <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            wr_ack     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            rd_valid   <= 1'b0;
            wr_ack     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        error <= 1'b0;
                        if (num_words == '0) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            busy  <= 1'b1;
                            state <= ARB;
                        end
                    end
                end
                ARB: begin
                    if (rd_done && wr_done) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (pick_rd) begin
                        re_q       <= 1'b1;
                        raddr_q    <= rd_addr;
                        last_grant <= READ;
                        wait_cnt   <= '0;
                        state      <= RD_WAIT;
                    end else if (pick_wr) begin
                        we_q       <= 1'b1;
                        waddr_q    <= wr_addr;
                        wdata_q    <= wr_data;
                        last_grant <= WRITE;
                        wait_cnt   <= '0;
                        state      <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.read_complete) begin
                        rd_data  <= bus.sram_data;
                        rd_valid <= 1'b1;
                        state    <= ARB;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (bus.write_complete) begin
                        wr_ack <= 1'b1;
                        state  <= ARB;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.re           = re_q;
    assign bus.we           = we_q;
    assign bus.next_raddr   = raddr_q;
    assign bus.next_waddr   = waddr_q;
    assign bus.buffer2_data = wdata_q;

endmodule

// File: tb/tb_ahb_xfer_scheduler.sv
// Self-checking bench for ahb_xfer_scheduler: table-driven frames plus
// hand-written timeout, spurious-completion, reset and empty-frame sequences.
module tb_ahb_xfer_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] rd_base;
    logic [31:0] wr_base;
    logic [15:0] num_words;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        busy;
    logic        frame_done;
    logic        error;

    ahb_xfer_scheduler_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    ahb_xfer_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_base    (rd_base),
        .wr_base    (wr_base),
        .num_words  (num_words),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .error      (error),
        .bus        (bus_if)
    );

    typedef struct {
        logic [31:0] rd_base;
        logic [31:0] wr_base;
        logic [15:0] nw;
        logic        rq;
        logic        wq;
        int          exp_re;
        int          exp_we;
        logic [31:0] exp_first_raddr;
        logic [31:0] exp_last_raddr;
        logic [31:0] exp_last_waddr;
        int          exp_done;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[5];

    int n_tests = 0;
    int n_fail  = 0;

    bit auto_rd = 0;
    bit auto_wr = 0;
    int rd_lat  = 2;
    int wr_lat  = 2;
    int rd_cd   = -1;
    int wr_cd   = -1;
    int rd_resp_cnt = 0;
    int wr_ack_seen = 0;

    logic [31:0] raddr_q[$];
    logic [31:0] waddr_q[$];
    logic [31:0] wdata_q[$];
    logic [31:0] rdata_q[$];
    int          order_q[$];
    int done_cnt = 0;
    int ack_cnt = 0;
    int valid_cnt = 0;
    int overlap_cnt = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    int last_done_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: log every strobe, ack, valid and frame_done seen mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus_if.re) begin
                raddr_q.push_back(bus_if.next_raddr);
                order_q.push_back(1);
            end
            if (bus_if.we) begin
                waddr_q.push_back(bus_if.next_waddr);
                wdata_q.push_back(bus_if.buffer2_data);
                order_q.push_back(2);
            end
            if (bus_if.re && bus_if.we) overlap_cnt++;
            if (rd_valid) begin
                rdata_q.push_back(rd_data);
                valid_cnt++;
            end
            if (wr_ack) begin
                ack_cnt++;
                last_ack_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    // AHB master model and write client: completions a fixed latency after each strobe
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                rd_cd = -1;
                wr_cd = -1;
            end
            if (auto_rd) begin
                bus_if.read_complete = (rd_cd == 0);
                if (rd_cd == 0) begin
                    bus_if.sram_data = 32'hD000_0000 + 32'(rd_resp_cnt);
                    rd_resp_cnt++;
                end
            end
            if (auto_wr) bus_if.write_complete = (wr_cd == 0);
            if (rd_cd >= 0) rd_cd--;
            if (wr_cd >= 0) wr_cd--;
            if (bus_if.re && auto_rd) rd_cd = rd_lat - 1;
            if (bus_if.we && auto_wr) wr_cd = wr_lat - 1;
            if (wr_ack) begin
                wr_ack_seen++;
                wr_data = 32'hC0DE_0000 + 32'(wr_ack_seen);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        raddr_q.delete();
        waddr_q.delete();
        wdata_q.delete();
        rdata_q.delete();
        order_q.delete();
        done_cnt = 0;
        ack_cnt = 0;
        valid_cnt = 0;
        overlap_cnt = 0;
        rd_resp_cnt = 0;
        wr_ack_seen = 0;
        wr_data = 32'hC0DE_0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        clear_mon();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return bus_if.re;
            1:       return bus_if.we;
            default: return error;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (probe(which)) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        do_reset();
        rd_base   = v.rd_base;
        wr_base   = v.wr_base;
        num_words = v.nw;
        rd_req    = v.rq;
        wr_req    = v.wq;
        pulse_start();
        tick(150);
    endtask

    initial begin
        int c;
        int hit;

        rst = 1'b1;
        start = 1'b0;
        rd_base = '0;
        wr_base = '0;
        num_words = '0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        wr_data = 32'hC0DE_0000;
        bus_if.read_complete = 1'b0;
        bus_if.write_complete = 1'b0;
        bus_if.sram_data = '0;

        vecs[0] = '{32'h0000_0100, 32'h0000_0800, 16'd4, 1'b1, 1'b0, 4, 0,
                    32'h0000_0100, 32'h0000_010C, 32'h0, 0, 1'b1};
        vecs[1] = '{32'h0000_2000, 32'h0000_3000, 16'd2, 1'b1, 1'b1, 2, 2,
                    32'h0000_2000, 32'h0000_2004, 32'h0000_3004, 1, 1'b0};
        vecs[2] = '{32'h0000_0100, 32'h0000_0800, 16'd0, 1'b1, 1'b1, 0, 0,
                    32'h0, 32'h0, 32'h0, 1, 1'b0};
        vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0010, 16'd2, 1'b1, 1'b0, 2, 0,
                    32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 0, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0040, 16'd3, 1'b0, 1'b1, 0, 3,
                    32'h0, 32'h0, 32'h0000_0048, 0, 1'b1};

        // Reset state with rst held
        tick(3);
        check_output("reset_ctrl", {61'd0, rd_valid, wr_ack, busy}, 64'd0);
        check_output("reset_flags", {60'd0, frame_done, error, bus_if.re, bus_if.we}, 64'd0);
        check_output("reset_data", {63'd0, |{rd_data, bus_if.next_raddr, bus_if.next_waddr, bus_if.buffer2_data}}, 64'd0);

        // Table-driven frames
        auto_rd = 1;
        auto_wr = 1;
        rd_lat = 2;
        wr_lat = 2;
        for (int v = 0; v < 5; v++) begin
            apply_stimulus(vecs[v]);
            check_output($sformatf("v%0d_re_count", v), 64'(raddr_q.size()), 64'(vecs[v].exp_re));
            check_output($sformatf("v%0d_we_count", v), 64'(waddr_q.size()), 64'(vecs[v].exp_we));
            if (vecs[v].exp_re > 0 && raddr_q.size() > 0) begin
                check_output($sformatf("v%0d_first_raddr", v), 64'(raddr_q[0]), 64'(vecs[v].exp_first_raddr));
                check_output($sformatf("v%0d_last_raddr", v), 64'(raddr_q[raddr_q.size()-1]), 64'(vecs[v].exp_last_raddr));
            end
            if (vecs[v].exp_we > 0 && waddr_q.size() > 0)
                check_output($sformatf("v%0d_last_waddr", v), 64'(waddr_q[waddr_q.size()-1]), 64'(vecs[v].exp_last_waddr));
            for (int i = 0; i < rdata_q.size(); i++)
                check_output($sformatf("v%0d_rd_data%0d", v, i), 64'(rdata_q[i]), 64'(32'hD000_0000 + 32'(i)));
            for (int i = 0; i < wdata_q.size(); i++)
                check_output($sformatf("v%0d_wdata%0d", v, i), 64'(wdata_q[i]), 64'(32'hC0DE_0000 + 32'(i)));
            check_output($sformatf("v%0d_frame_done", v), 64'(done_cnt), 64'(vecs[v].exp_done));
            check_output($sformatf("v%0d_busy", v), 64'(busy), 64'(vecs[v].exp_busy));
            check_output($sformatf("v%0d_overlap", v), 64'(overlap_cnt), 64'd0);
        end

        // Fair alternation with immediate completions
        rd_lat = 1;
        wr_lat = 1;
        do_reset();
        rd_base = 32'h100;
        wr_base = 32'h800;
        num_words = 16'd2;
        rd_req = 1'b1;
        wr_req = 1'b1;
        pulse_start();
        tick(60);
        check_output("alt_count", 64'(order_q.size()), 64'd4);
        if (order_q.size() == 4) begin
            check_output("alt_0", 64'(order_q[0]), 64'd1);
            check_output("alt_1", 64'(order_q[1]), 64'd2);
            check_output("alt_2", 64'(order_q[2]), 64'd1);
            check_output("alt_3", 64'(order_q[3]), 64'd2);
        end
        if (waddr_q.size() == 2) begin
            check_output("alt_waddr1", 64'(waddr_q[1]), 64'h804);
            check_output("alt_wdata1", 64'(wdata_q[1]), 64'hC0DE_0001);
        end
        check_output("alt_done_cnt", 64'(done_cnt), 64'd1);
        check_output("alt_done_after_ack", 64'(last_done_cyc > last_ack_cyc), 64'd1);
        check_output("alt_busy", 64'(busy), 64'd0);

        // Empty frame
        do_reset();
        num_words = 16'd0;
        pulse_start();
        check_output("empty_done", 64'(frame_done), 64'd1);
        check_output("empty_busy", 64'(busy), 64'd0);
        tick(1);
        check_output("empty_done_pulse", 64'(frame_done), 64'd0);
        tick(5);
        check_output("empty_no_strobe", 64'(order_q.size()), 64'd0);

        // Timeout on a withheld read completion, then recovery by a new start
        auto_rd = 0;
        do_reset();
        rd_base = 32'h500;
        num_words = 16'd1;
        rd_req = 1'b1;
        wr_req = 1'b0;
        pulse_start();
        wait_for(0, 10, c);
        check_output("to_re_seen", 64'(c != -1), 64'd1);
        hit = -1;
        for (int k = 1; k <= 400; k++) begin
            tick(1);
            if (error) begin
                hit = k;
                break;
            end
        end
        check_output("to_cycles", 64'(hit), 64'd256);
        check_output("to_busy", 64'(busy), 64'd0);
        check_output("to_re", 64'(bus_if.re), 64'd0);
        auto_rd = 1;
        rd_base = 32'h600;
        pulse_start();
        check_output("to_err_clear", 64'(error), 64'd0);
        check_output("to_busy_again", 64'(busy), 64'd1);
        wait_for(0, 10, c);
        check_output("to_re_again", 64'(c != -1), 64'd1);
        check_output("to_new_raddr", 64'(bus_if.next_raddr), 64'h600);

        // Spurious completions and start while busy
        auto_rd = 0;
        auto_wr = 0;
        bus_if.read_complete = 1'b0;
        bus_if.write_complete = 1'b0;
        do_reset();
        bus_if.read_complete = 1'b1;
        tick(1);
        bus_if.read_complete = 1'b0;
        tick(2);
        check_output("idle_rc_ignored", 64'(valid_cnt), 64'd0);
        rd_base = 32'h700;
        num_words = 16'd2;
        rd_req = 1'b1;
        pulse_start();
        wait_for(0, 10, c);
        check_output("sp_re_seen", 64'(c != -1), 64'd1);
        rd_base = 32'hAAA0;
        start = 1'b1;
        bus_if.write_complete = 1'b1;
        tick(1);
        start = 1'b0;
        bus_if.write_complete = 1'b0;
        tick(2);
        check_output("sp_wc_ignored", 64'(ack_cnt), 64'd0);
        check_output("sp_still_busy", 64'(busy), 64'd1);
        bus_if.read_complete = 1'b1;
        tick(1);
        bus_if.read_complete = 1'b0;
        wait_for(0, 10, c);
        check_output("sp_re2_seen", 64'(c != -1), 64'd1);
        check_output("sp_raddr2", 64'(bus_if.next_raddr), 64'h704);
        check_output("sp_valid_cnt", 64'(valid_cnt), 64'd1);

        // Reset while waiting on a write, with a completion arriving the same cycle
        do_reset();
        wr_base = 32'h900;
        num_words = 16'd1;
        rd_req = 1'b0;
        wr_req = 1'b1;
        pulse_start();
        wait_for(1, 10, c);
        check_output("rw_we_seen", 64'(c != -1), 64'd1);
        rst = 1'b1;
        bus_if.write_complete = 1'b1;
        tick(1);
        bus_if.write_complete = 1'b0;
        check_output("rw_ctrl", {58'd0, rd_valid, wr_ack, busy, frame_done, error, bus_if.re}, 64'd0);
        check_output("rw_we", 64'(bus_if.we), 64'd0);
        check_output("rw_data", {63'd0, |{rd_data, bus_if.next_raddr, bus_if.next_waddr, bus_if.buffer2_data}}, 64'd0);
        rst = 1'b0;
        tick(5);
        check_output("rw_no_ack", 64'(ack_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
